// File: rtl/memchip_arbiter_2p_if.sv
// memchip_arbiter_2p_if
//   Bundles the two requester ports and the memchip_64 side of the arbiter.
//   The slave modport is the arbiter's view.
//   The master modport is the environment's view: the two bus masters plus the memory.
interface memchip_arbiter_2p_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [5:0]  addr0;
  logic [5:0]  addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [15:0] rdata0;
  logic [15:0] rdata1;
  logic        err0;
  logic        err1;
  logic [5:0]  mem_addr;
  logic [15:0] mem_in;
  logic        mem_rw;
  logic [15:0] mem_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    output ack0, ack1, rdata0, rdata1, err0, err1, mem_addr, mem_in, mem_rw
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    input  ack0, ack1, rdata0, rdata1, err0, err1, mem_addr, mem_in, mem_rw
  );
endinterface

// File: rtl/memchip_arbiter_2p.sv
// memchip_arbiter_2p
//   Round-robin two-port arbiter and access sequencer for the 64x16 memchip_64.
//
//   Memory map:
//     ROM  0x00-0x0F
//     RAM1 0x10-0x17
//     RAM2 0x28-0x2F
//
//   Sequence: IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> RESP -> IDLE.
//   The memory's RW strobe is level sensitive. Address and data therefore
//   settle one cycle (SETUP) before RW rises and stay put one cycle (HOLD)
//   after it falls.
//
//   Optional feature macro: MEMARB_ERR_EN.
//   When defined, unmapped addresses and ROM writes are faulted. A faulted
//   request spends its SETUP cycle without touching the memory and then
//   responds with ack+err. When undefined, err0/err1 are constant 0.
module memchip_arbiter_2p #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  memchip_arbiter_2p_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_RESP
  } state_t;

  localparam logic [2:0] LP_LAST_CNT = 3'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic        r_last;
  logic        r_grant;
  logic        r_we;
  logic        r_fault;
  logic [2:0]  r_cnt;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_err0;
  logic        r_err1;
  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;
  logic [5:0]  r_memAddr;
  logic [15:0] r_memIn;
  logic        r_memRw;

  logic        w_anyReq;
  logic        w_sel;
  logic        w_selWe;
  logic [5:0]  w_selAddr;
  logic [15:0] w_selWdata;
  logic        w_fault;

  // Round-robin choice: on contention the port that was not served last wins.
  always_comb begin
    w_anyReq   = bus.req0 | bus.req1;
    w_sel      = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    w_selWe    = w_sel ? bus.we1    : bus.we0;
    w_selAddr  = w_sel ? bus.addr1  : bus.addr0;
    w_selWdata = w_sel ? bus.wdata1 : bus.wdata0;
  end

`ifdef MEMARB_ERR_EN
  // Fault decode on the selected request: unmapped holes or a write into ROM.
  always_comb begin
    w_fault = ((w_selAddr >= 6'h18) && (w_selAddr <= 6'h27)) ||
              (w_selAddr >= 6'h30) ||
              (w_selWe && (w_selAddr <= 6'h0F));
  end
`else
  // Without fault checking every request takes the full memory path.
  always_comb begin
    w_fault = 1'b0;
  end
`endif

  // Sequencer FSM with registered acks, errors, read data and memory strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_grant   <= 1'b0;
      r_we      <= 1'b0;
      r_fault   <= 1'b0;
      r_cnt     <= 3'd0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_rdata0  <= 16'h0000;
      r_rdata1  <= 16'h0000;
      r_memAddr <= 6'h00;
      r_memIn   <= 16'h0000;
      r_memRw   <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_grant <= w_sel;
            r_last  <= w_sel;
            r_we    <= w_selWe;
            r_fault <= w_fault;
            if (!w_fault) begin
              r_memAddr <= w_selAddr;
              r_memIn   <= w_selWdata;
            end
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt <= 3'd0;
          if (r_fault) begin
            r_ack0  <= ~r_grant;
            r_ack1  <= r_grant;
            r_err0  <= ~r_grant;
            r_err1  <= r_grant;
            r_state <= S_RESP;
          end else begin
            r_memRw <= r_we;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == LP_LAST_CNT) begin
            r_memRw <= 1'b0;
            if (!r_we) begin
              if (r_grant) begin
                r_rdata1 <= bus.mem_out;
              end else begin
                r_rdata0 <= bus.mem_out;
              end
            end
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_HOLD: begin
          r_ack0  <= ~r_grant;
          r_ack1  <= r_grant;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_memRw <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.err0     = r_err0;
  assign bus.err1     = r_err1;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;
  assign bus.mem_addr = r_memAddr;
  assign bus.mem_in   = r_memIn;
  assign bus.mem_rw   = r_memRw;

endmodule
